key_conditioner: RTL

Input-conditioning stage between the board push-buttons and the `main` display/control logic. It synchronizes, debounces and edge-detects each raw `KEY` input and generates single-cycle press, release and auto-repeat strobes. `main` therefore sees clean one-clock events instead of bouncing asynchronous levels.

---
 rtl/key_pkg.sv | 23 ++
 rtl/key_lane.sv | 131 +++++++++++++
 rtl/key_conditioner.sv | 40 ++++
 3 files changed

// File: rtl/key_pkg.sv
// Shared types and constants for the push-button conditioner.
package key_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESSED,
      REPEAT
   } key_state_e;

   localparam int unsigned DEB_CYCLES_DEF    = 50000;
   localparam int unsigned REPEAT_DELAY_DEF  = 25000000;
   localparam int unsigned REPEAT_PERIOD_DEF = 5000000;

   localparam int unsigned DEB_CYCLES_SIM    = 4;
   localparam int unsigned REPEAT_DELAY_SIM  = 20;
   localparam int unsigned REPEAT_PERIOD_SIM = 8;

   // Counter width able to hold n-1, never narrower than one bit.
   function automatic int cnt_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/key_lane.sv
// One key lane: synchronizer, debounce, press/hold FSM and strobes.
module key_lane
   import key_pkg::*;
#(
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
   parameter bit          REPEAT_EN     = 1'b1,
   parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);

   localparam int unsigned HOLD_MAX =
      (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int DEB_W  = cnt_w(DEB_CYCLES);
   localparam int HOLD_W = cnt_w(HOLD_MAX);

   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] DLY_LAST = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] PER_LAST = HOLD_W'(REPEAT_PERIOD - 1);

   logic [1:0]        sync_q;
   logic [DEB_W-1:0]  deb_q, deb_d;
   logic              lvl_q, lvl_d;
   key_state_e        state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              press_q, press_d;
   logic              rel_q, rel_d;
   logic              rep_q, rep_d;
   logic              rise, fall;

   // Level flips only after DEB_CYCLES consecutive mismatching samples.
   always_comb begin
      lvl_d = lvl_q;
      deb_d = '0;
      if (sync_q[1] != lvl_q) begin
         if (deb_q == DEB_LAST) begin
            lvl_d = ~lvl_q;
         end else begin
            deb_d = deb_q + 1'b1;
         end
      end
   end

   assign rise = lvl_d & ~lvl_q;
   assign fall = ~lvl_d & lvl_q;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      rep_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            hold_d = '0;
            if (rise) begin
               state_d = PRESSED;
               press_d = 1'b1;
            end
         end
         PRESSED: begin
            if (fall) begin
               state_d = IDLE;
               rel_d   = 1'b1;
               hold_d  = '0;
            end else if (hold_q == DLY_LAST) begin
               hold_d = '0;
               if (REPEAT_EN) begin
                  state_d = REPEAT;
                  rep_d   = 1'b1;
               end
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         REPEAT: begin
            // A release on the terminal-count edge wins over the repeat.
            if (fall) begin
               state_d = IDLE;
               rel_d   = 1'b1;
               hold_d  = '0;
            end else if (hold_q == PER_LAST) begin
               hold_d = '0;
               rep_d  = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         deb_q   <= '0;
         lvl_q   <= 1'b0;
         state_q <= IDLE;
         hold_q  <= '0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         rep_q   <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], key_i ^ ACTIVE_LOW};
         deb_q   <= deb_d;
         lvl_q   <= lvl_d;
         state_q <= state_d;
         hold_q  <= hold_d;
         press_q <= press_d;
         rel_q   <= rel_d;
         rep_q   <= rep_d;
      end
   end

   assign level_o   = lvl_q;
   assign press_o   = press_q;
   assign release_o = rel_q;
   assign repeat_o  = rep_q;

endmodule

// File: rtl/key_conditioner.sv
// Push-button conditioner: NKEYS independent debounced lanes with
// press, release and auto-repeat strobes.
module key_conditioner
   import key_pkg::*;
#(
   parameter int unsigned NKEYS         = 3,
   parameter bit          ACTIVE_LOW    = 1'b1,
   parameter int unsigned DEB_CYCLES    = DEB_CYCLES_DEF,
   parameter bit          REPEAT_EN     = 1'b1,
   parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NKEYS-1:0] key_in,
   output logic [NKEYS-1:0] key_level,
   output logic [NKEYS-1:0] key_press,
   output logic [NKEYS-1:0] key_release,
   output logic [NKEYS-1:0] key_repeat
);

   for (genvar i = 0; i < NKEYS; i++) begin : g_lane
      key_lane #(
         .ACTIVE_LOW   (ACTIVE_LOW),
         .DEB_CYCLES   (DEB_CYCLES),
         .REPEAT_EN    (REPEAT_EN),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .key_i    (key_in[i]),
         .level_o  (key_level[i]),
         .press_o  (key_press[i]),
         .release_o(key_release[i]),
         .repeat_o (key_repeat[i])
      );
   end

endmodule
